// File: rtl/ds_dac_pkg.sv
// Shared types and arithmetic for the multi-channel delta-sigma DAC.
// - ds_order_t : modulator order selector
// - sat_add    : saturating a + b - c at integrator width, with overflow flag
// - FB_MAG     : feedback magnitude, one half of PCM full scale
// The integrator width is fixed here by DS_W/DS_AW; keep the W/AW
// parameters of ds_dac_mc equal to these values.
package ds_dac_pkg;

    localparam int unsigned DS_W   = 16;
    localparam int unsigned DS_AW  = 4;
    localparam int unsigned DS_IW  = DS_W + DS_AW;
    localparam int unsigned SUM_W  = DS_IW + 2;
    localparam int unsigned FB_MAG = 2 ** (DS_W - 1);

    typedef enum logic {
        DS_ORD1 = 1'b0,
        DS_ORD2 = 1'b1
    } ds_order_t;

    typedef logic signed [DS_IW-1:0] ds_int_t;

    typedef struct packed {
        ds_int_t val;
        logic    ovf;
    } sat_res_t;

    // Three DS_IW operands cannot exceed SUM_W bits, so the top bits show overflow.
    function automatic sat_res_t sat_add(input ds_int_t a, input ds_int_t b, input ds_int_t c);
        logic signed [SUM_W-1:0] sum;
        sat_res_t                res;
        sum     = SUM_W'(a) + SUM_W'(b) - SUM_W'(c);
        res.val = DS_IW'(sum);
        res.ovf = 1'b0;
        if (sum[SUM_W-1:DS_IW-1] != {(SUM_W-DS_IW+1){sum[SUM_W-1]}}) begin
            res.ovf = 1'b1;
            res.val = sum[SUM_W-1] ? {1'b1, {(DS_IW-1){1'b0}}} : {1'b0, {(DS_IW-1){1'b1}}};
        end
        return res;
    endfunction

endpackage

// File: rtl/ds_mod_ch.sv
// One delta-sigma modulator channel: active sample, 1st-order accumulator,
// 2nd-order integrators, PDM bit and sticky overload flag.
// Ports: clk, reset_n; run (0 = hold zero state, pdm 0); order; load/sample
// (commit into active); clr_ovl; pdm and ovl (registered).
module ds_mod_ch
    import ds_dac_pkg::*;
#(
    parameter int unsigned W  = DS_W,
    parameter int unsigned AW = DS_AW,
    parameter int unsigned FB = FB_MAG
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         run,
    input  ds_order_t    order,
    input  logic         load,
    input  logic [W-1:0] sample,
    input  logic         clr_ovl,
    output logic         pdm,
    output logic         ovl
);

    localparam int unsigned IW = W + AW;

    logic [W-1:0]         active_q, active_d;
    logic [W-1:0]         acc_q, acc_d;
    logic signed [IW-1:0] i1_q, i1_d, i2_q, i2_d;
    logic                 pdm_q, pdm_d;
    logic                 ovl_q, ovl_d;
    logic [W:0]           sum1;
    logic signed [IW-1:0] act_s, fb;
    sat_res_t             s1, s2;

    // Next-state for both modulator orders; non-running cycles return to zero state.
    always_comb begin
        active_d = load ? sample : active_q;
        acc_d    = '0;
        i1_d     = '0;
        i2_d     = '0;
        pdm_d    = 1'b0;
        ovl_d    = ovl_q & ~clr_ovl;

        // Flipping the sign bit gives the offset-binary value active + 2^(W-1).
        sum1  = {1'b0, acc_q} + {1'b0, ~active_q[W-1], active_q[W-2:0]};
        act_s = IW'(signed'(active_q));
        fb    = pdm_q ? IW'(FB) : -IW'(FB);
        s1    = sat_add(ds_int_t'(i1_q), ds_int_t'(act_s), ds_int_t'(fb));
        s2    = sat_add(ds_int_t'(i2_q), ds_int_t'(i1_q), ds_int_t'(fb));

        if (run) begin
            if (order == DS_ORD1) begin
                acc_d = sum1[W-1:0];
                pdm_d = sum1[W];
            end else begin
                i1_d  = IW'(s1.val);
                i2_d  = IW'(s2.val);
                pdm_d = ~i2_d[IW-1];
                // Saturation set wins over a simultaneous clear.
                ovl_d = ovl_d | s1.ovf | s2.ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= '0;
            acc_q    <= '0;
            i1_q     <= '0;
            i2_q     <= '0;
            pdm_q    <= 1'b0;
            ovl_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            acc_q    <= acc_d;
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            pdm_q    <= pdm_d;
            ovl_q    <= ovl_d;
        end
    end

    assign pdm = pdm_q;
    assign ovl = ovl_q;

endmodule

// File: rtl/ds_dac_mc.sv
// Multi-channel delta-sigma DAC with 1-bit PDM output per channel.
// Ports: clk, reset_n (async, active low); en; order2; pcm_valid/pcm_ready/
// pcm_ch/pcm_data sample write into shadow registers; pcm_commit copies all
// shadows to the active samples; clr_ovl; pdm_out and overload per channel.
module ds_dac_mc
    import ds_dac_pkg::*;
#(
    parameter int unsigned W    = DS_W,
    parameter int unsigned CH   = 2,
    parameter int unsigned AW   = DS_AW,
    localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic           order2,
    input  logic           pcm_valid,
    output logic           pcm_ready,
    input  logic [CHW-1:0] pcm_ch,
    input  logic [W-1:0]   pcm_data,
    input  logic           pcm_commit,
    input  logic           clr_ovl,
    output logic [CH-1:0]  pdm_out,
    output logic [CH-1:0]  overload
);

    logic         ready_q, ready_d;
    ds_order_t    order_q, order_d;
    logic [W-1:0] shadow_q [CH];
    logic [W-1:0] shadow_d [CH];
    logic         wr_ok;
    logic         run;

    // Shadow write, order tracking and channel run qualifier.
    always_comb begin
        ready_d  = 1'b1;
        order_d  = ds_order_t'(order2);
        shadow_d = shadow_q;
        // Out-of-range channels complete the handshake but store nothing.
        wr_ok    = pcm_valid && ready_q && (32'(pcm_ch) < CH);
        if (wr_ok) begin
            shadow_d[pcm_ch] = pcm_data;
        end
        // An order change costs one zero-state cycle so the new order starts clean.
        run = en && (order_d == order_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            order_q <= DS_ORD1;
            for (int unsigned k = 0; k < CH; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            ready_q  <= ready_d;
            order_q  <= order_d;
            shadow_q <= shadow_d;
        end
    end

    assign pcm_ready = ready_q;

    // Commit takes shadow_d so a same-cycle write commits its new data.
    for (genvar k = 0; k < CH; k++) begin : g_ch
        ds_mod_ch #(
            .W  (W),
            .AW (AW),
            .FB (FB_MAG)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .run     (run),
            .order   (order_q),
            .load    (pcm_commit),
            .sample  (shadow_d[k]),
            .clr_ovl (clr_ovl),
            .pdm     (pdm_out[k]),
            .ovl     (overload[k])
        );
    end

endmodule
